psnoc_rr_arbiter: RTL and testbench
===================================

// Module: psnoc_rr_arbiter
// PURPOSE
//  Parametrised round-robin arbiter for PSNoC crossbar output ports. Picks one of NUM_REQ
//  requesters with a thermometer priority mask and registers a one-hot grant. The grant is
//  held across a whole packet (PACKET_MODE=1) or a burst of up to MAX_BEATS beats
//  (PACKET_MODE=0), then priority rotates past the winner. Drives the crossbar mux select.
// PARAMETERS
//  NUM_REQ      4  number of requesters, >=2
//  PACKET_MODE  1  1: hold grant until tail beat accepted; 0: hold for MAX_BEATS beats
//  MAX_BEATS    1  beats per grant when PACKET_MODE=0, >=1; ignored when PACKET_MODE=1
//  IDX_W        $clog2(NUM_REQ)  width of grant_idx (derived, do not override)
// PORTS
//  clk         in   1        clock
//  rst         in   1        asynchronous reset, active-high
//  req         in   NUM_REQ  per-requester request, level, held until granted beats sent
//  last        in   NUM_REQ  per-requester tail flag, qualifies the current beat
//  out_ready   in   1        downstream accepts the granted requester's beat this cycle
//  grant       out  NUM_REQ  registered one-hot grant, all-zero when idle
//  grant_valid out  1        registered, 1 iff grant != 0
//  grant_idx   out  IDX_W    binary index of grant bit; 0 when idle
//  beat_xfer   out  1        combinational: grant_valid & req[grant_idx] & out_ready
// BEHAVIOUR
//  Reset (async, rst=1): grant=0, grant_valid=0, grant_idx=0, prio_mask=all-ones,
//   beat_cnt=0, state IDLE. Outputs are registered; beat_xfer is 0 while in reset.
//  Arbitration (combinational, "pick"): masked=req&prio_mask; if masked!=0 winner=lowest
//   set bit of masked, else lowest set bit of req; none if req==0.
//  States: IDLE, BUSY.
//   IDLE: if req!=0, register grant=onehot(pick), beat_cnt=0, ->BUSY (1-cycle req->grant).
//   BUSY: requester g held. Release condition in a cycle:
//    - PACKET_MODE=1: beat_xfer & last[g];
//    - PACKET_MODE=0: beat_xfer & (beat_cnt==MAX_BEATS-1);
//    - abort: req[g]==0 (any mode, no transfer occurs in that cycle).
//   On beat_xfer without release: beat_cnt++ (saturates at MAX_BEATS-1, PACKET_MODE=1 does
//   not use it for release).
//   On release at edge: prio_mask <= bits strictly above g set (g==NUM_REQ-1 -> all-ones);
//   pick is re-evaluated the same cycle with the NEW mask and current req excluding g's
//   request only through the mask; if a winner exists grant switches at that edge
//   (no idle bubble) and beat_cnt=0, else ->IDLE with grant=0.
//  Priority mask updates only on release; never on grant in IDLE.
//  Sole requester: released g is re-granted next edge if it is the only req (fallback).
//  Grant never changes while BUSY except at a release edge; req changes of other
//   requesters are ignored until then.
//  last is only sampled on beat_xfer; last on a non-granted requester has no effect.
//  out_ready while IDLE has no effect; beat_xfer is 0.
//  Reset asserted mid-packet: immediate return to reset values; no partial rotation kept.
// TESTING
//  1 Reset then req=4'b1010, last=0 -> cycle 1 grant=4'b0010, grant_idx=1, grant_valid=1.
//  2 PACKET_MODE=1, req=4'b1111, out_ready=1, last high every 3rd beat -> grants rotate
//    0,1,2,3,0, each held exactly 3 beat_xfer cycles, no idle cycle between grants.
//  3 Grant on 3 with req=4'b1001 released -> next grant 0 (mask wrap to all-ones).
//  4 Granted requester 2 drops req mid-packet -> abort, grant moves to 3 if req[3],
//    else 0/1 via fallback, prio_mask = 4'b1000.
//  5 PACKET_MODE=0, MAX_BEATS=2, req=4'b0011, out_ready toggling 1,0,1 -> grant 0 held
//    until 2nd accepted beat, then grant 1; out_ready=0 cycles do not advance beat_cnt.
//  6 Assert rst while BUSY on requester 1 -> grant=0 same cycle; after release with
//    req=4'b0110, first grant is 1 (mask all-ones), not 2.

Source files
------------

// File: rtl/psnoc_rr_arbiter.sv
// Round-robin output-port arbiter for the PSNoC crossbar. It registers a one-hot grant and holds it
// for a whole packet or a fixed beat burst, then rotates priority past the winner.
module psnoc_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter bit PACKET_MODE = 1'b1,
  parameter int MAX_BEATS   = 1,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               beat_xfer
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q, prio_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               held, at_max, done, rel;
  logic [NUM_REQ-1:0] above, rel_mask_d, pick_mask, masked, win_d;
  logic [IDX_W-1:0]   win_idx_d;

  function automatic logic [NUM_REQ-1:0] lowest(input logic [NUM_REQ-1:0] v);
    return v & (~v + ONE);
  endfunction

  always_comb begin
    held      = |(req & grant_q);
    beat_xfer = valid_q & held & out_ready;
    at_max    = (cnt_q == CNT_MAX);
    done      = PACKET_MODE ? (beat_xfer & |(last & grant_q)) : (beat_xfer & at_max);
    // A dropped request on the held port frees the output just like a completed packet.
    rel       = (state_q == BUSY) & (done | ~held);
    above     = ~(grant_q | (grant_q - ONE));
    rel_mask_d = (above == '0) ? '1 : above;
    // On a release edge the new mask is used immediately, so a waiting requester gets no bubble.
    pick_mask = rel ? rel_mask_d : prio_q;
    masked    = req & pick_mask;
    win_d     = (masked != '0) ? lowest(masked) : lowest(req);
    win_idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_d[i]) win_idx_d = IDX_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      prio_q  <= '1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != '0) begin
            grant_q <= win_d;
            idx_q   <= win_idx_d;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (rel) begin
            prio_q <= rel_mask_d;
            cnt_q  <= '0;
            if (req != '0) begin
              grant_q <= win_d;
              idx_q   <= win_idx_d;
            end else begin
              grant_q <= '0;
              idx_q   <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end else if (beat_xfer && !at_max) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_psnoc_rr_arbiter.sv
// Directed bench for psnoc_rr_arbiter. Instance A runs in packet mode and instance B in
// burst mode with MAX_BEATS=2.
module tb_psnoc_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a = '0, last_a = '0, req_b = '0, last_b = '0;
  logic       rdy_a = 1'b0, rdy_b = 1'b0;
  logic [3:0] grant_a, grant_b;
  logic       gv_a, gv_b, bx_a, bx_b;
  logic [1:0] gi_a, gi_b;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  psnoc_rr_arbiter #(.NUM_REQ(4), .PACKET_MODE(1'b1), .MAX_BEATS(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .last(last_a), .out_ready(rdy_a),
    .grant(grant_a), .grant_valid(gv_a), .grant_idx(gi_a), .beat_xfer(bx_a));

  psnoc_rr_arbiter #(.NUM_REQ(4), .PACKET_MODE(1'b0), .MAX_BEATS(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .last(last_b), .out_ready(rdy_b),
    .grant(grant_b), .grant_valid(gv_b), .grant_idx(gi_b), .beat_xfer(bx_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_a = '0; last_a = '0; rdy_a = 1'b0;
    req_b = '0; last_b = '0; rdy_b = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_a = 4'b1111; rdy_a = 1'b1;
    tick; #1;
    total_cnt++; if (grant_a !== 4'b0000) $display("FAIL rst_grant got=%b exp=0000", grant_a); else pass_cnt++;
    total_cnt++; if (gv_a !== 1'b0) $display("FAIL rst_valid got=%b exp=0", gv_a); else pass_cnt++;
    total_cnt++; if (gi_a !== 2'd0) $display("FAIL rst_idx got=%0d exp=0", gi_a); else pass_cnt++;
    total_cnt++; if (bx_a !== 1'b0) $display("FAIL rst_xfer got=%b exp=0", bx_a); else pass_cnt++;
    do_reset;
  endtask

  task automatic test_first_grant;
    do_reset;
    req_a = 4'b1010;
    tick;
    total_cnt++; if (grant_a !== 4'b0010) $display("FAIL first_grant got=%b exp=0010", grant_a); else pass_cnt++;
    total_cnt++; if (gi_a !== 2'd1) $display("FAIL first_idx got=%0d exp=1", gi_a); else pass_cnt++;
    total_cnt++; if (gv_a !== 1'b1) $display("FAIL first_valid got=%b exp=1", gv_a); else pass_cnt++;
    total_cnt++; if (bx_a !== 1'b0) $display("FAIL first_xfer_noready got=%b exp=0", bx_a); else pass_cnt++;
  endtask

  task automatic test_rotation;
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    do_reset;
    req_a = 4'b1111; rdy_a = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << seq[k];
      for (int b = 0; b < 3; b++) begin
        // Non-granted tails are raised on early beats and must be ignored.
        last_a = (b == 2) ? 4'b1111 : ~exp_g;
        #1;
        total_cnt++;
        if (grant_a !== exp_g || bx_a !== 1'b1 || gi_a !== 2'(seq[k]))
          $display("FAIL rot_g%0d_b%0d got=%b/%b/%0d exp=%b/1/%0d", k, b, grant_a, bx_a, gi_a, exp_g, seq[k]);
        else pass_cnt++;
        tick;
      end
    end
  endtask

  task automatic test_wrap;
    do_reset;
    req_a = 4'b1000; rdy_a = 1'b0;
    tick;
    total_cnt++; if (grant_a !== 4'b1000) $display("FAIL wrap_g3 got=%b exp=1000", grant_a); else pass_cnt++;
    req_a = 4'b1001; last_a = 4'b1000; rdy_a = 1'b1;
    tick;
    total_cnt++; if (grant_a !== 4'b0001) $display("FAIL wrap_next got=%b exp=0001", grant_a); else pass_cnt++;
    last_a = 4'b0001;
    tick;
    total_cnt++; if (grant_a !== 4'b1000) $display("FAIL wrap_rot got=%b exp=1000", grant_a); else pass_cnt++;
  endtask

  task automatic test_abort;
    do_reset;
    req_a = 4'b0100; rdy_a = 1'b1; last_a = 4'b0000;
    tick;
    req_a = 4'b1101;
    tick;
    total_cnt++; if (grant_a !== 4'b0100) $display("FAIL abort_hold got=%b exp=0100", grant_a); else pass_cnt++;
    req_a = 4'b1011;
    #1;
    total_cnt++; if (bx_a !== 1'b0) $display("FAIL abort_xfer got=%b exp=0", bx_a); else pass_cnt++;
    tick;
    total_cnt++; if (grant_a !== 4'b1000) $display("FAIL abort_to3 got=%b exp=1000", grant_a); else pass_cnt++;
    do_reset;
    req_a = 4'b0100; rdy_a = 1'b1;
    tick;
    req_a = 4'b0011;
    tick;
    // Mask 1000 leaves nothing eligible, so the fallback picks the lowest raw request.
    total_cnt++; if (grant_a !== 4'b0001) $display("FAIL abort_fallback got=%b exp=0001", grant_a); else pass_cnt++;
    total_cnt++; if (gi_a !== 2'd0) $display("FAIL abort_fb_idx got=%0d exp=0", gi_a); else pass_cnt++;
  endtask

  task automatic test_burst;
    do_reset;
    req_b = 4'b0011; rdy_b = 1'b0;
    tick;
    total_cnt++; if (grant_b !== 4'b0001) $display("FAIL burst_g0 got=%b exp=0001", grant_b); else pass_cnt++;
    rdy_b = 1'b1; #1;
    total_cnt++; if (bx_b !== 1'b1) $display("FAIL burst_xfer1 got=%b exp=1", bx_b); else pass_cnt++;
    tick;
    total_cnt++; if (grant_b !== 4'b0001) $display("FAIL burst_hold1 got=%b exp=0001", grant_b); else pass_cnt++;
    rdy_b = 1'b0;
    tick;
    total_cnt++; if (grant_b !== 4'b0001) $display("FAIL burst_hold_stall got=%b exp=0001", grant_b); else pass_cnt++;
    rdy_b = 1'b1;
    tick;
    total_cnt++; if (grant_b !== 4'b0010) $display("FAIL burst_g1 got=%b exp=0010", grant_b); else pass_cnt++;
    tick;
    total_cnt++; if (grant_b !== 4'b0010) $display("FAIL burst_g1_hold got=%b exp=0010", grant_b); else pass_cnt++;
    tick;
    total_cnt++; if (grant_b !== 4'b0001) $display("FAIL burst_g0_again got=%b exp=0001", grant_b); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_a = 4'b0010; rdy_a = 1'b1; last_a = 4'b0010;
    tick;
    tick;
    // Sole requester is re-granted while the mask now favours requester 2.
    total_cnt++; if (grant_a !== 4'b0010) $display("FAIL sole_regrant got=%b exp=0010", grant_a); else pass_cnt++;
    last_a = 4'b0000; req_a = 4'b0110;
    #2; rst = 1'b1; #1;
    total_cnt++; if (grant_a !== 4'b0000 || gv_a !== 1'b0) $display("FAIL midrst_clear got=%b/%b exp=0000/0", grant_a, gv_a); else pass_cnt++;
    total_cnt++; if (bx_a !== 1'b0) $display("FAIL midrst_xfer got=%b exp=0", bx_a); else pass_cnt++;
    rst = 1'b0;
    tick;
    total_cnt++; if (grant_a !== 4'b0010) $display("FAIL midrst_after got=%b exp=0010", grant_a); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_first_grant;
    test_rotation;
    test_wrap;
    test_abort;
    test_burst;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
